// File: rtl/bf16_divider_if.sv
// Operand/result handshake bundle for the BF16 divider.
// The slave side is the divider; the master side is whoever issues divisions.
interface bf16_divider_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/bf16_divider.sv
// Iterative BF16 divider: specials resolve at accept, normal operands run a
// 9-step restoring mantissa division (one quotient bit per cycle), truncating.
module bf16_divider (
    input  logic          clk,
    input  logic          rst,
    bf16_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t             state, state_nx;
    logic [3:0]         cnt;
    logic [8:0]         rem;
    logic [7:0]         mb;
    logic [8:0]         quo;
    logic signed [9:0]  ediff;
    logic               sign;
    logic [15:0]        result;

    // Operand classification; subnormals are flushed to zero here.
    logic [7:0]  ea, eb;
    logic [6:0]  fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s_in;
    logic        special, accept;
    logic [15:0] special_res;

    always_comb begin
        ea     = bus.in_a[14:7];
        eb     = bus.in_b[14:7];
        fa     = bus.in_a[6:0];
        fb     = bus.in_b[6:0];
        s_in   = bus.in_a[15] ^ bus.in_b[15];
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == 8'hFF) && (fa == 7'h0);
        b_inf  = (eb == 8'hFF) && (fb == 7'h0);
        a_nan  = (ea == 8'hFF) && (fa != 7'h0);
        b_nan  = (eb == 8'hFF) && (fb != 7'h0);

        special     = 1'b1;
        special_res = 16'h0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            special_res = 16'h7FC0;
        else if (a_inf || b_zero)
            special_res = {s_in, 8'hFF, 7'h0};
        else if (a_zero || b_inf)
            special_res = {s_in, 15'h0};
        else
            special = 1'b0;
    end

    assign accept = bus.in_valid && (state == IDLE);

    // One restoring step: compare, conditionally subtract, shift.
    logic       ge;
    logic [8:0] rem_sub, rem_nx;

    always_comb begin
        ge      = (rem >= {1'b0, mb});
        rem_sub = ge ? (rem - {1'b0, mb}) : rem;
        rem_nx  = {rem_sub[7:0], 1'b0};
    end

    // Normalisation and range clamp of the finished quotient.
    logic signed [9:0] e_norm;
    logic [6:0]        frac_norm;
    logic [15:0]       norm_res;

    always_comb begin
        e_norm    = quo[8] ? (ediff + 10'sd127) : (ediff + 10'sd126);
        frac_norm = quo[8] ? quo[7:1] : quo[6:0];
        if (e_norm >= 10'sd255)
            norm_res = {sign, 8'hFF, 7'h0};
        else if (e_norm <= 10'sd0)
            norm_res = {sign, 15'h0};
        else
            norm_res = {sign, e_norm[7:0], frac_norm};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = special ? DONE : DIV;
            DIV:  if (cnt == 4'd0) state_nx = NORM;
            NORM: state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 4'd0;
            rem    <= 9'd0;
            mb     <= 8'd0;
            quo    <= 9'd0;
            ediff  <= 10'sd0;
            sign   <= 1'b0;
            result <= 16'h0000;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sign  <= s_in;
                    ediff <= $signed({2'b00, ea}) - $signed({2'b00, eb});
                    rem   <= {2'b01, fa};
                    mb    <= {1'b1, fb};
                    quo   <= 9'd0;
                    cnt   <= 4'd8;
                    if (special) result <= special_res;
                end
                DIV: begin
                    rem <= rem_nx;
                    quo <= {quo[7:0], ge};
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                NORM: result <= norm_res;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = result;
endmodule

// File: tb/tb_bf16_divider.sv
// Scoreboard bench for bf16_divider: expected quotients/latencies are queued
// at issue and popped when the result appears.
module tb_bf16_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;

    bf16_divider_if bus();

    bf16_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Waits for in_ready, queues the expectation, presents operands for one edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_d, input int exp_lat);
        int guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%b want 1", bus.in_ready);
        end
        exp_q.push_back('{data: exp_d, lat: exp_lat});
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
    endtask

    // Counts edges after the accept edge until out_valid, bounded.
    task automatic wait_result(output logic [15:0] d, output int lat, output bit ok);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = (bus.out_valid === 1'b1);
        d  = bus.out_data;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++;
        if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h want 0000", bus.out_data); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ops(input string name, input logic [15:0] ta[], input logic [15:0] tb[],
                            input logic [15:0] te[], input int tl);
        logic [15:0] d;
        int          lat;
        bit          ok;
        exp_t        e;
        bus.out_ready = 1'b1;
        for (int i = 0; i < ta.size(); i++) begin
            send(ta[i], tb[i], te[i], tl);
            wait_result(d, lat, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || d !== e.data) begin
                errors++;
                $display("FAIL %s_data[%0d] %h/%h got %h valid=%b want %h", name, i, ta[i], tb[i], d, ok, e.data);
            end
            checks++;
            if (lat !== e.lat) begin
                errors++;
                $display("FAIL %s_latency[%0d] got %0d want %0d", name, i, lat, e.lat);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s_release[%0d] out_valid=%b in_ready=%b want 0/1", name, i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_normal;
        logic [15:0] ta[] = '{16'h4040, 16'h3F80, 16'hC040, 16'h4000, 16'h3F80};
        logic [15:0] tb[] = '{16'h3FC0, 16'h4040, 16'h3FC0, 16'h4000, 16'h4000};
        logic [15:0] te[] = '{16'h4000, 16'h3EAA, 16'hC000, 16'h3F80, 16'h3F00};
        test_ops("normal", ta, tb, te, 10);
    endtask

    task automatic test_special;
        logic [15:0] ta[] = '{16'h3F80, 16'h8000, 16'h7FC1, 16'h3F80, 16'h0001, 16'h7F80, 16'hFF80};
        logic [15:0] tb[] = '{16'h0000, 16'h8000, 16'h3F80, 16'hFF80, 16'h3F80, 16'h7F80, 16'h3F80};
        logic [15:0] te[] = '{16'h7F80, 16'h7FC0, 16'h7FC0, 16'h8000, 16'h0000, 16'h7FC0, 16'hFF80};
        test_ops("special", ta, tb, te, 0);
    endtask

    task automatic test_range;
        logic [15:0] ta[] = '{16'h7F00, 16'h0080};
        logic [15:0] tb[] = '{16'h0080, 16'h7F00};
        logic [15:0] te[] = '{16'h7F80, 16'h0000};
        test_ops("range", ta, tb, te, 10);
    endtask

    task automatic test_backpressure;
        logic [15:0] d;
        int          lat;
        bit          ok;
        exp_t        e;
        int          bad = 0;
        bus.out_ready = 1'b0;
        send(16'h4040, 16'h3FC0, 16'h4000, 10);
        wait_result(d, lat, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || d !== e.data) begin
            errors++;
            $display("FAIL bp_data got %h valid=%b want %h", d, ok, e.data);
        end
        // A special operand pair waiting on the input must not be captured.
        bus.in_a     = 16'h3F80;
        bus.in_b     = 16'h0000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold %0d bad cycles, last out_valid=%b out_data=%h in_ready=%b want 1/%h/0",
                     bad, bus.out_valid, bus.out_data, bus.in_ready, e.data);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 16'h4000) begin
            errors++;
            $display("FAIL bp_no_capture out_data got %h want 4000", bus.out_data);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] d;
        int          lat;
        bit          ok;
        exp_t        e;
        int          spurious = 0;
        bus.out_ready = 1'b1;
        send(16'h3F80, 16'h4040, 16'h3EAA, 10);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.out_data !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid_out_data got %h want 0000", bus.out_data);
        end
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL rst_mid_lost out_valid high %0d cycles want 0", spurious);
        end
        send(16'h4040, 16'h3FC0, 16'h4000, 10);
        wait_result(d, lat, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || d !== e.data || lat !== e.lat) begin
            errors++;
            $display("FAIL rst_mid_next got %h lat %0d want %h lat %0d", d, lat, e.data, e.lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [15:0] ta[] = '{16'h4040, 16'h3F80, 16'hC040, 16'h7F00, 16'h4000, 16'h3F80};
        logic [15:0] tb[] = '{16'h3FC0, 16'h0000, 16'h3FC0, 16'h0080, 16'h4000, 16'h4040};
        logic [15:0] te[] = '{16'h4000, 16'h7F80, 16'hC000, 16'h7F80, 16'h3F80, 16'h3EAA};
        int          tl[] = '{10, 0, 10, 10, 10, 10};
        logic [15:0] d;
        int          lat;
        bit          ok;
        exp_t        e;
        bus.out_ready = 1'b1;
        foreach (ta[i]) send(ta[i], tb[i], te[i], tl[i]) ;
    endtask

    task automatic test_pipeline_flow;
        logic [15:0] ta[] = '{16'h4040, 16'h3F80, 16'hC040, 16'h7F00, 16'h4000};
        logic [15:0] tb[] = '{16'h3FC0, 16'h0000, 16'h3FC0, 16'h0080, 16'h4000};
        logic [15:0] te[] = '{16'h4000, 16'h7F80, 16'hC000, 16'h7F80, 16'h3F80};
        int          tl[] = '{10, 0, 10, 10, 10};
        logic [15:0] d;
        int          lat;
        bit          ok;
        exp_t        e;
        bus.out_ready = 1'b1;
        for (int i = 0; i < ta.size(); i++) begin
            send(ta[i], tb[i], te[i], tl[i]);
            wait_result(d, lat, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || d !== e.data || lat !== e.lat) begin
                errors++;
                $display("FAIL b2b[%0d] got %h lat %0d want %h lat %0d", i, d, lat, e.data, e.lat);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_scoreboard_left %0d want 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = 16'h0000;
        bus.in_b      = 16'h0000;
        bus.out_ready = 1'b1;
        test_reset();
        test_normal();
        test_special();
        test_range();
        test_backpressure();
        test_reset_mid();
        test_pipeline_flow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
